imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the single-cycle immediate generator. It extracts and extends RISC-V immediates for XLEN=32 or 64 and adds the formats the single-cycle block lacks: U-type, CSR zimm, and an illegal-select flag. A 2-entry registered buffer with valid/ready handshakes on both sides lets it sit between the decode and execute stages of the pipelined core. A sideband tag (e.g. rd or ROB index) travels alongside each immediate, and a saturating counter records illegal selects.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
TAG_W, 8, width of the sideband tag carried with each entry.
ERR_CNT_W, 8, width of the saturating illegal-select counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
in_valid  in  1  input entry valid.
in_ready  out  1  buffer can accept an entry; equals (count != 2).
instr  in  25  instruction bits [31:7]; index 0 corresponds to instruction bit 7.
imm_sel  in  4  format select.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  head entry valid; equals (count != 0).
out_ready  in  1  consumer accepts the head entry.
imm_out  out  XLEN  immediate of the head entry.
out_tag  out  TAG_W  tag of the head entry.
imm_err  out  1  head entry had an illegal imm_sel.
err_count  out  ERR_CNT_W  saturating count of accepted illegal entries.

Behaviour:
- Handshake: push = in_valid & in_ready; pop = out_valid & out_ready. A transfer occurs only in a cycle where both signals are high.
- Format decode is combinational at push. Below, ib(n) is instruction bit n; sext/zext extend to XLEN.
  - 0 I: sext(ib31:20).
  - 1 SHAMT: zext(ib24:20) when XLEN=32; zext(ib25:20) when XLEN=64. Zero-extended; this is a deliberate change from sign extension.
  - 2 S: sext({ib31:25, ib11:7}).
  - 3 B: sext({ib31, ib7, ib30:25, ib11:8, 0}).
  - 4 I-unsigned: zext(ib31:20).
  - 5 U: sext({ib31:12, 12'b0}).
  - 6 J: sext({ib31, ib19:12, ib20, ib30:21, 0}).
  - 7 B-unsigned: zext of the 13-bit B value.
  - 8 ZIMM: zext(ib19:15).
  - 9..15: illegal. Stored imm = 0 and stored err = 1.
- Storage is a 2-entry FIFO with wrapping rd_ptr/wr_ptr and count in 0..2. Each entry holds {imm, tag, err}.
- There is no combinational path from input to output.
  - Minimum latency: push in cycle N gives out_valid in cycle N+1.
  - Throughput: 1 entry/cycle when out_ready is held high.
- Simultaneous push and pop:
  - count=1: count stays 1, pointers advance.
  - count=0: push only, since out_valid=0.
  - count=2: pop only, since in_ready=0. in_ready rises in the cycle after the pop.
- Ordering: strict FIFO. out_tag always matches the imm_out it was pushed with.
- Outputs while count=0: imm_out, out_tag and imm_err drive 0.
- Output stability: while out_valid=1 and out_ready=0, the outputs hold stable.
- err_count increments by 1 on each push with an illegal select. It saturates at 2^ERR_CNT_W-1 and never wraps.
- Reset (rst_n=0 at a rising edge), including mid-operation:
  - count, pointers and err_count are cleared to 0; all entry contents are discarded.
  - After that edge: out_valid=0, imm_out=0, out_tag=0, imm_err=0, err_count=0, in_ready=1.
  - A push presented in the reset cycle is dropped.
- Inputs are don't-care when in_valid=0.

Test Plan:
- Single I-type: instr=0xFFF00093 (addi x1,x0,-1) sent as bits[31:7], sel=0, tag=0x11, out_ready=1 -> next cycle out_valid=1, imm_out=0xFFFFFFFF, out_tag=0x11, imm_err=0; cycle after that, out_valid=0.
- Streaming, all formats, XLEN=32: back-to-back pushes with out_ready=1.
  - jal x0,-4, instr 0xFFDFF06F, sel=6 -> 0xFFFFFFFC.
  - Same instr, sel=5 -> 0xFFDFF000.
  - instr 0x01F00093, sel=1 -> 0x0000001F.
  - csrrwi zimm=31, sel=8 -> 0x0000001F.
  - Required: one result per cycle, in push order.
- Backpressure: out_ready=0, push tags 1,2,3 on consecutive cycles.
  - in_ready=0 after the second push; tag 3 is held at the input.
  - Raise out_ready -> tags pop 1, 2, 3 in order; outputs stable while stalled; no entry lost or duplicated.
- Illegal select: sel=4'hA -> imm_out=0, imm_err=1, err_count 0->1. With ERR_CNT_W=2, push 5 illegals -> err_count stays at 3.
- Reset mid-operation: buffer full (count=2), err_count=2, rst_n=0 for one edge -> out_valid=0, in_ready=1, err_count=0, imm_out=0; a subsequent push returns correct data with 1-cycle latency.
- XLEN=64:
  - lui instr 0x800000B7, sel=5 -> 0xFFFFFFFF80000000.
  - SHAMT with ib25:20=63 -> 0x000000000000003F.
  - B-type offset -2 with sel=7 -> 0x0000000000001FFE; with sel=3 -> 0xFFFFFFFFFFFFFFFE.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Purpose: RISC-V immediate extract/extend (XLEN 32/64) with tag sideband, illegal-select flag and counter.
// Latency: 1 cycle from accepted push to out_valid; 1 entry/cycle sustained with out_ready held high.
// Backpressure: 2-entry buffer; in_ready drops when full, head entry held stable while out_ready is low.
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [24:0]          instr,
  input  logic [3:0]           imm_sel,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      imm_out,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 imm_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef logic [XLEN-1:0] xlen_t;

  // Instruction bits renumbered so ib[n] is architectural instruction bit n.
  logic [31:7] ib;
  assign ib = instr;

  xlen_t dec_imm;
  logic  dec_err;

  // Storage: two entries, wrapping 1-bit pointers, occupancy 0..2.
  xlen_t            imm_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic             err_q [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic push;
  logic pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Format decode at the input; casts of signed values sign-extend, unsigned ones zero-extend.
  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    case (imm_sel)
      4'd0: dec_imm = xlen_t'($signed(ib[31:20]));
      4'd1: begin
        if (XLEN == 64) dec_imm = xlen_t'(ib[25:20]);
        else            dec_imm = xlen_t'(ib[24:20]);
      end
      4'd2: dec_imm = xlen_t'($signed({ib[31:25], ib[11:7]}));
      4'd3: dec_imm = xlen_t'($signed({ib[31], ib[7], ib[30:25], ib[11:8], 1'b0}));
      4'd4: dec_imm = xlen_t'(ib[31:20]);
      4'd5: dec_imm = xlen_t'($signed({ib[31:12], 12'b0}));
      4'd6: dec_imm = xlen_t'($signed({ib[31], ib[19:12], ib[20], ib[30:21], 1'b0}));
      4'd7: dec_imm = xlen_t'({ib[31], ib[7], ib[30:25], ib[11:8], 1'b0});
      4'd8: dec_imm = xlen_t'(ib[19:15]);
      default: begin
        dec_imm = '0;
        dec_err = 1'b1;
      end
    endcase
  end

  // Entry payload write; contents need no reset because occupancy gates the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_q[wr_ptr] <= dec_imm;
      tag_q[wr_ptr] <= in_tag;
      err_q[wr_ptr] <= dec_err;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards everything held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of accepted illegal selects; holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (push && dec_err && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

  // Head entry presented from registers only; zeros when empty.
  always_comb begin
    imm_out = '0;
    out_tag = '0;
    imm_err = 1'b0;
    if (out_valid) begin
      imm_out = imm_q[rd_ptr];
      out_tag = tag_q[rd_ptr];
      imm_err = err_q[rd_ptr];
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit instance (2-bit error counter) and a 64-bit instance
// driven in lockstep, with a queue of expected head entries checked every cycle.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [24:0] instr;
  logic [3:0]  imm_sel;
  logic [7:0]  in_tag;

  logic        in_ready32, out_valid32, imm_err32;
  logic [31:0] imm_out32;
  logic [7:0]  out_tag32;
  logic [1:0]  err_count32;

  logic        in_ready64, out_valid64, imm_err64;
  logic [63:0] imm_out64;
  logic [7:0]  out_tag64;
  logic [7:0]  err_count64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .ERR_CNT_W(2)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .imm_out(imm_out32),
    .out_tag(out_tag32), .imm_err(imm_err32), .err_count(err_count32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .ERR_CNT_W(8)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .imm_out(imm_out64),
    .out_tag(out_tag64), .imm_err(imm_err64), .err_count(err_count64)
  );

  typedef struct {
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  int   checks = 0;
  int   failures = 0;
  int   ec32 = 0;
  int   ec64 = 0;
  logic accepted;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: compare outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    exp_t h;
    logic push, pop;
    @(negedge clk);
    h = '{imm32: 64'd0, imm64: 64'd0, tag: 8'd0, err: 1'b0};
    if (q.size() != 0) h = q[0];
    chk("in_ready32",  {63'd0, in_ready32},  {63'd0, q.size() != 2});
    chk("in_ready64",  {63'd0, in_ready64},  {63'd0, q.size() != 2});
    chk("out_valid32", {63'd0, out_valid32}, {63'd0, q.size() != 0});
    chk("out_valid64", {63'd0, out_valid64}, {63'd0, q.size() != 0});
    chk("imm_out32",   {32'd0, imm_out32},   h.imm32);
    chk("imm_out64",   imm_out64,            h.imm64);
    chk("out_tag32",   {56'd0, out_tag32},   {56'd0, h.tag});
    chk("out_tag64",   {56'd0, out_tag64},   {56'd0, h.tag});
    chk("imm_err32",   {63'd0, imm_err32},   {63'd0, h.err});
    chk("imm_err64",   {63'd0, imm_err64},   {63'd0, h.err});
    chk("err_count32", {62'd0, err_count32}, 64'(ec32));
    chk("err_count64", {56'd0, err_count64}, 64'(ec64));
    push = in_valid && (q.size() < 2) && rst_n;
    pop  = (q.size() != 0) && out_ready && rst_n;
    accepted = push;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      ec32 = 0;
      ec64 = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(pend);
        if (pend.err) begin
          if (ec32 < 3)   ec32++;
          if (ec64 < 255) ec64++;
        end
      end
    end
    #1;
  endtask

  task automatic set_in(input logic [31:0] ins, input logic [3:0] sel, input logic [7:0] tag,
                        input logic [63:0] e32, input logic [63:0] e64, input logic err);
    in_valid = 1'b1;
    instr    = ins[31:7];
    imm_sel  = sel;
    in_tag   = tag;
    pend     = '{imm32: e32, imm64: e64, tag: tag, err: err};
  endtask

  // Present an entry and keep it there until the buffer takes it (bounded).
  task automatic send(input logic [31:0] ins, input logic [3:0] sel, input logic [7:0] tag,
                      input logic [63:0] e32, input logic [63:0] e64, input logic err);
    set_in(ins, sel, tag, e32, e64, err);
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (accepted) break;
    end
    if (!accepted) chk("send_timeout", {63'd0, accepted}, 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; imm_sel = '0; in_tag = '0;
    pend = '{imm32: 64'd0, imm64: 64'd0, tag: 8'd0, err: 1'b0};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Single I-type: addi x1,x0,-1
    send(32'hFFF00093, 4'd0, 8'h11, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    idle(2);

    // Back-to-back stream across every legal format
    send(32'hFFDFF06F, 4'd6, 8'h21, 64'h0000_0000_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'hFFDFF06F, 4'd5, 8'h22, 64'h0000_0000_FFDF_F000, 64'hFFFF_FFFF_FFDF_F000, 1'b0);
    send(32'h01F00093, 4'd1, 8'h23, 64'h0000_0000_0000_001F, 64'h0000_0000_0000_001F, 1'b0);
    send(32'h340FD0F3, 4'd8, 8'h24, 64'h0000_0000_0000_001F, 64'h0000_0000_0000_001F, 1'b0);
    send(32'hFFF00093, 4'd4, 8'h25, 64'h0000_0000_0000_0FFF, 64'h0000_0000_0000_0FFF, 1'b0);
    send(32'hFE112C23, 4'd2, 8'h26, 64'h0000_0000_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    send(32'hFE000FE3, 4'd3, 8'h27, 64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    send(32'hFE000FE3, 4'd7, 8'h28, 64'h0000_0000_0000_1FFE, 64'h0000_0000_0000_1FFE, 1'b0);
    send(32'h800000B7, 4'd5, 8'h29, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(32'h03F09093, 4'd1, 8'h2A, 64'h0000_0000_0000_001F, 64'h0000_0000_0000_003F, 1'b0);
    idle(2);

    // Backpressure: fill, hold the third entry at the input, then drain in order
    out_ready = 1'b0;
    send(32'hFFF00093, 4'd0, 8'h01, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(32'h800000B7, 4'd5, 8'h02, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    set_in(32'h340FD0F3, 4'd8, 8'h03, 64'h0000_0000_0000_001F, 64'h0000_0000_0000_001F, 1'b0);
    step();
    step();
    out_ready = 1'b1;
    send(32'h340FD0F3, 4'd8, 8'h03, 64'h0000_0000_0000_001F, 64'h0000_0000_0000_001F, 1'b0);
    idle(3);

    // Illegal select
    send(32'h12345678, 4'hA, 8'h55, 64'd0, 64'd0, 1'b1);
    idle(2);

    // Reset while full with a push presented
    out_ready = 1'b0;
    send(32'h12345678, 4'hF, 8'h66, 64'd0, 64'd0, 1'b1);
    send(32'hFFF00093, 4'd0, 8'h77, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    set_in(32'hFFF00093, 4'd4, 8'h88, 64'h0000_0000_0000_0FFF, 64'h0000_0000_0000_0FFF, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(1);
    out_ready = 1'b1;
    send(32'hFE112C23, 4'd2, 8'h99, 64'h0000_0000_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    idle(2);

    // Counter saturation on the narrow counter
    for (int i = 0; i < 5; i++) begin
      send(32'hFFFFFFFF, 4'(9 + i), 8'(8'hA0 + i), 64'd0, 64'd0, 1'b1);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
